// File: rtl/alu_serial_ctrl.sv
// Byte-stream sequencer for the ALU: collects A, B and op code from RX, executes, sends result on TX.
// Optional ALU_CTRL_FLAGS_EN: a second TX byte {0.., carry, zero} follows each result byte.
module alu_serial_ctrl #(
  parameter int unsigned NB_DATA        = 8,
  parameter int unsigned NB_OP_CODE     = 6,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [NB_DATA-1:0]    i_rx_data,
  input  logic                  i_rx_valid,
  input  logic                  i_tx_busy,
  input  logic                  i_tx_done,
  output logic [NB_DATA-1:0]    o_tx_data,
  output logic                  o_tx_start,
  output logic [NB_DATA-1:0]    o_data_a,
  output logic [NB_DATA-1:0]    o_data_b,
  output logic [NB_OP_CODE-1:0] o_op_code,
  input  logic [NB_DATA-1:0]    i_alu_result,
  input  logic                  i_alu_zero,
  input  logic                  i_alu_carry,
  output logic                  o_busy,
  output logic                  o_rx_drop,
  output logic                  o_timeout
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StWaitA,
    StWaitB,
    StWaitOp,
    StExec,
    StSendRes,
    StWaitTx,
    StSendFlg
  } state_e;

  state_e                  state_q;
  logic [CntW-1:0]         cnt_q;
  logic [NB_DATA-1:0]      data_a_q;
  logic [NB_DATA-1:0]      data_b_q;
  logic [NB_OP_CODE-1:0]   op_q;
  logic [NB_DATA-1:0]      result_q;
  logic [NB_DATA-1:0]      tx_data_q;
  logic                    tx_start_q;
  logic                    busy_q;
  logic                    rx_drop_q;
  logic                    timeout_q;
`ifdef ALU_CTRL_FLAGS_EN
  logic                    zero_q;
  logic                    carry_q;
  logic                    flg_phase_q;
`else
  logic                    unused_flags;
  assign unused_flags = i_alu_zero ^ i_alu_carry;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StWaitA;
      cnt_q      <= '0;
      data_a_q   <= '0;
      data_b_q   <= '0;
      op_q       <= '0;
      result_q   <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      rx_drop_q  <= 1'b0;
      timeout_q  <= 1'b0;
`ifdef ALU_CTRL_FLAGS_EN
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      flg_phase_q <= 1'b0;
`endif
    end else begin
      tx_start_q <= 1'b0;
      rx_drop_q  <= 1'b0;
      timeout_q  <= 1'b0;
      unique case (state_q)
        StWaitA: begin
          cnt_q <= '0;
          if (i_rx_valid) begin
            data_a_q <= i_rx_data;
            state_q  <= StWaitB;
          end
        end
        StWaitB, StWaitOp: begin
          // A byte arriving in the terminal cycle takes priority over the timeout.
          if (i_rx_valid) begin
            cnt_q <= '0;
            if (state_q == StWaitB) begin
              data_b_q <= i_rx_data;
              state_q  <= StWaitOp;
            end else begin
              op_q    <= i_rx_data[NB_OP_CODE-1:0];
              busy_q  <= 1'b1;
              state_q <= StExec;
            end
          end else if (cnt_q == CntMax) begin
            cnt_q     <= '0;
            timeout_q <= 1'b1;
            state_q   <= StWaitA;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StExec: begin
          rx_drop_q <= i_rx_valid;
          result_q  <= i_alu_result;
`ifdef ALU_CTRL_FLAGS_EN
          zero_q    <= i_alu_zero;
          carry_q   <= i_alu_carry;
`endif
          // Start straight from EXEC when TX is free to keep two-cycle latency.
          if (!i_tx_busy) begin
            tx_data_q  <= i_alu_result;
            tx_start_q <= 1'b1;
            state_q    <= StWaitTx;
          end else begin
            state_q <= StSendRes;
          end
        end
        StSendRes: begin
          rx_drop_q <= i_rx_valid;
          if (!i_tx_busy) begin
            tx_data_q  <= result_q;
            tx_start_q <= 1'b1;
            state_q    <= StWaitTx;
          end
        end
        StWaitTx: begin
          rx_drop_q <= i_rx_valid;
          if (i_tx_done) begin
`ifdef ALU_CTRL_FLAGS_EN
            if (!flg_phase_q) begin
              flg_phase_q <= 1'b1;
              state_q     <= StSendFlg;
            end else begin
              flg_phase_q <= 1'b0;
              busy_q      <= 1'b0;
              state_q     <= StWaitA;
            end
`else
            busy_q  <= 1'b0;
            state_q <= StWaitA;
`endif
          end
        end
`ifdef ALU_CTRL_FLAGS_EN
        StSendFlg: begin
          rx_drop_q <= i_rx_valid;
          if (!i_tx_busy) begin
            tx_data_q  <= {{(NB_DATA-2){1'b0}}, carry_q, zero_q};
            tx_start_q <= 1'b1;
            state_q    <= StWaitTx;
          end
        end
`endif
        default: begin
          busy_q  <= 1'b0;
          state_q <= StWaitA;
        end
      endcase
    end
  end

  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_data_a   = data_a_q;
  assign o_data_b   = data_b_q;
  assign o_op_code  = op_q;
  assign o_busy     = busy_q;
  assign o_rx_drop  = rx_drop_q;
  assign o_timeout  = timeout_q;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Randomized self-checking bench for alu_serial_ctrl with a behavioural ALU and reference model.
module tb_alu_serial_ctrl;
  localparam int T = 40;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid, tx_busy, tx_done;
  logic [7:0] tx_data, data_a, data_b;
  logic       tx_start, busy, rx_drop, timeout;
  logic [5:0] op_code;
  logic [9:0] alu_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Reference ALU: returns {carry, zero, result}.
  function automatic logic [9:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                           input logic [5:0] op);
    logic [7:0] r;
    logic       c;
    int         s;
    c = 1'b0;
    case (op)
      6'h20: begin s = int'(a) + int'(b); r = s[7:0]; c = (s > 255); end
      6'h22: begin r = a - b; c = (a >= b); end
      6'h24: r = a & b;
      6'h25: r = a | b;
      6'h26: r = a ^ b;
      6'h27: r = ~(a | b);
      6'h02: r = a >> b[2:0];
      6'h03: r = $signed(a) >>> b[2:0];
      default: r = 8'h00;
    endcase
    return {c, (r == 8'h00), r};
  endfunction

  assign alu_out = alu_model(data_a, data_b, op_code);

  alu_serial_ctrl #(.NB_DATA(8), .NB_OP_CODE(6), .TIMEOUT_CYCLES(T)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_rx_data   (rx_data),
    .i_rx_valid  (rx_valid),
    .i_tx_busy   (tx_busy),
    .i_tx_done   (tx_done),
    .o_tx_data   (tx_data),
    .o_tx_start  (tx_start),
    .o_data_a    (data_a),
    .o_data_b    (data_b),
    .o_op_code   (op_code),
    .i_alu_result(alu_out[7:0]),
    .i_alu_zero  (alu_out[8]),
    .i_alu_carry (alu_out[9]),
    .o_busy      (busy),
    .o_rx_drop   (rx_drop),
    .o_timeout   (timeout)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic do_cmd(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                        input int gap, input int hold);
    logic [9:0] e;
    int         early;
    e = alu_model(a, b, opb[5:0]);
    send_byte(a);
    repeat (gap) @(negedge clk);
    send_byte(b);
    repeat (gap) @(negedge clk);
    if (hold > 0) tx_busy = 1'b1;
    send_byte(opb);
    checks++;
    if ({data_a, data_b, op_code} !== {a, b, opb[5:0]}) begin
      errors++;
      $display("FAIL operands: got %h/%h/%h expected %h/%h/%h", data_a, data_b, op_code,
               a, b, opb[5:0]);
    end
    checks++;
    if ({busy, tx_start} !== 2'b10) begin
      errors++;
      $display("FAIL exec_cycle: busy,start got %b expected 10", {busy, tx_start});
    end
    if (hold > 0) begin
      early = 0;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (tx_start) early++;
      end
      checks++;
      if (early != 0) begin
        errors++;
        $display("FAIL busy_hold: got %0d starts while busy expected 0", early);
      end
      tx_busy = 1'b0;
    end
    @(negedge clk);
    checks++;
    if ({tx_start, tx_data} !== {1'b1, e[7:0]}) begin
      errors++;
      $display("FAIL result_tx: start,data got %b,%h expected 1,%h", tx_start, tx_data, e[7:0]);
    end
    tx_busy = 1'b1;
    @(negedge clk);
    checks++;
    if ({tx_start, tx_data} !== {1'b0, e[7:0]}) begin
      errors++;
      $display("FAIL result_hold: start,data got %b,%h expected 0,%h", tx_start, tx_data, e[7:0]);
    end
    repeat (2) @(negedge clk);
    tx_busy = 1'b0;
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
`ifdef ALU_CTRL_FLAGS_EN
    @(negedge clk);
    checks++;
    if ({tx_start, tx_data} !== {1'b1, 6'b0, e[9:8]}) begin
      errors++;
      $display("FAIL flags_tx: start,data got %b,%h expected 1,%h", tx_start, tx_data,
               {6'b0, e[9:8]});
    end
    @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
`endif
    early = 0;
    for (int i = 0; i < 4; i++) begin
      if (busy || tx_start) early++;
      @(negedge clk);
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL cmd_end: got %0d busy/start cycles after done expected 0", early);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_busy = 1'b0; tx_done = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx_data, tx_start, data_a, data_b, op_code, busy, rx_drop, timeout} !== '0) begin
      errors++;
      $display("FAIL reset_state: got %h,%b,%h,%h,%h,%b,%b,%b expected all 0", tx_data, tx_start,
               data_a, data_b, op_code, busy, rx_drop, timeout);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_spec_vectors;
    do_cmd(8'h05, 8'h03, 8'h20, 0, 0);
    do_cmd(8'h03, 8'h05, 8'h22, 0, 0);
    do_cmd(8'h05, 8'h05, 8'h22, 0, 0);
  endtask

  task automatic test_timeout;
    send_byte(8'h0F);
    for (int i = 0; i < T - 1; i++) begin
      @(negedge clk);
      checks++;
      if (timeout !== 1'b0) begin
        errors++;
        $display("FAIL timeout_early_b: cycle %0d got 1 expected 0", i);
      end
    end
    @(negedge clk);
    checks++;
    if ({timeout, data_a} !== {1'b1, 8'h0F}) begin
      errors++;
      $display("FAIL timeout_b: timeout,a got %b,%h expected 1,0f", timeout, data_a);
    end
    @(negedge clk);
    checks++;
    if (timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse: got 1 expected 0");
    end
    do_cmd(8'hF0, 8'h0F, 8'h25, 0, 0);
    send_byte(8'h11);
    send_byte(8'h66);
    repeat (T - 1) @(negedge clk);
    checks++;
    if (timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early_op: got 1 expected 0");
    end
    @(negedge clk);
    checks++;
    if ({timeout, data_b} !== {1'b1, 8'h66}) begin
      errors++;
      $display("FAIL timeout_op: timeout,b got %b,%h expected 1,66", timeout, data_b);
    end
    // Byte in the terminal cycle must be accepted.
    do_cmd(8'h21, 8'h13, 8'h26, T - 2, 0);
  endtask

  task automatic test_busy_hold;
    do_cmd(8'h7F, 8'h01, 8'h20, 0, 100);
    do_cmd(8'h80, 8'h02, 8'hC3, 1, 5);
  endtask

  task automatic test_rx_drop;
    @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h20);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = 8'hAA;
    @(negedge clk);
    rx_valid = 1'b0;
    checks++;
    if ({rx_drop, data_a, tx_data} !== {1'b1, 8'h11, 8'h33}) begin
      errors++;
      $display("FAIL rx_drop: drop,a,tx got %b,%h,%h expected 1,11,33", rx_drop, data_a, tx_data);
    end
    @(negedge clk);
    checks++;
    if (rx_drop !== 1'b0) begin
      errors++;
      $display("FAIL rx_drop_pulse: got 1 expected 0");
    end
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
`ifdef ALU_CTRL_FLAGS_EN
    repeat (2) @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
`endif
    @(negedge clk);
    do_cmd(8'h09, 8'h04, 8'h24, 0, 0);
  endtask

  task automatic test_reset_mid;
    int starts;
    send_byte(8'h12);
    send_byte(8'h34);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({data_a, data_b, busy, tx_start} !== '0) begin
      errors++;
      $display("FAIL reset_mid_cmd: a,b,busy,start got %h,%h,%b,%b expected 0", data_a, data_b,
               busy, tx_start);
    end
    @(negedge clk);
    rst_n = 1'b1;
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h20);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({tx_start, tx_data, busy, op_code} !== '0) begin
      errors++;
      $display("FAIL reset_mid_tx: start,data,busy,op got %b,%h,%b,%h expected 0", tx_start,
               tx_data, busy, op_code);
    end
    @(negedge clk);
    rst_n = 1'b1;
    send_byte(8'h01);
    starts = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx_start || busy) starts++;
    end
    checks++;
    if (starts != 0) begin
      errors++;
      $display("FAIL reset_no_tx: got %0d active cycles expected 0", starts);
    end
    // Drain the pending partial command before the next test.
    repeat (T) @(negedge clk);
  endtask

  task automatic test_random;
    logic [5:0] ops[9];
    logic [7:0] opb;
    int         gap, hold;
    ops = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h02, 6'h03, 6'h3F};
    for (int n = 0; n < 30; n++) begin
      opb  = {2'($urandom), ops[$urandom_range(0, 8)]};
      if (n % 7 == 6) opb[5:0] = 6'($urandom);
      gap  = ($urandom_range(0, 5) == 0) ? T - 2 : $urandom_range(0, 3);
      hold = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : 0;
      do_cmd(8'($urandom), 8'($urandom), opb, gap, hold);
    end
  endtask

  initial begin
    test_reset;
    test_spec_vectors;
    test_timeout;
    test_busy_hold;
    test_rx_drop;
    test_reset_mid;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
